// File: rtl/pump_duty_decoder_pkg.sv
// -----------------------------------------------------------------------------
// pump_duty_decoder_pkg
// Shared definitions for the pump PWM duty decoder and the VCXO controller:
// FSM state encoding, default measurement parameters and a small
// absolute-difference helper used by the lock qualification.
// -----------------------------------------------------------------------------
package pump_duty_decoder_pkg;

    // Full-scale PWM count of the VCXO controller; the pump PWM period is
    // nominally this many clk_in cycles, so the two blocks share the value.
    localparam int PWM_MAX = 32000;

    // Default decoder parameters.
    localparam int PERIOD_NOM_DEF = PWM_MAX;
    localparam int PERIOD_TOL_DEF = 16;
    localparam int STABLE_N_DEF   = 4;

    // Counter width: holds 2*PERIOD_NOM for any PERIOD_NOM <= 65535.
    localparam int CNT_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2
    } pdd_state_e;

    // |a - b| without wrap-around, for period and duty deviation checks.
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        if (a >= b) begin
            abs_diff = a - b;
        end else begin
            abs_diff = b - a;
        end
    endfunction

endpackage

// File: rtl/pump_duty_decoder_edge.sv
// -----------------------------------------------------------------------------
// pump_edge_sync
// Two-flop synchronizer for the asynchronous pump line followed by a
// registered rising-edge detector. level and rise are time-aligned: the cycle
// rise is high is also the first cycle level is high.
// Ports:
//   clk_in  - clock, rising edge
//   reset   - synchronous active-high reset, clears every flop
//   pump_in - asynchronous PWM pump line
//   level   - synchronized pump level (delayed copy of the sync flop)
//   rise    - one-cycle pulse on a synchronized 0->1 transition
// -----------------------------------------------------------------------------
module pump_edge_sync (
    input  logic clk_in,
    input  logic reset,
    input  logic pump_in,
    output logic level,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic rise_r;

    // Synchronizer chain and registered edge detector.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            meta_r <= pump_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise_r <= sync_r & ~prev_r;
        end
    end

    assign level = prev_r;
    assign rise  = rise_r;

endmodule

// File: rtl/pump_duty_decoder.sv
// -----------------------------------------------------------------------------
// pump_duty_decoder
// Measures period and high-time of the pump PWM line, flags stuck lines and
// qualifies a stable (locked) PWM.
// Parameters:
//   PERIOD_NOM - nominal PWM period in clk_in cycles
//   PERIOD_TOL - allowed period deviation for a good period
//   STABLE_N   - consecutive good periods needed for locked
// Ports:
//   clk_in, reset      - clock and synchronous active-high reset
//   enable             - low halts measurement and discards a partial period
//   pump_in            - asynchronous pump PWM line
//   duty, period       - high-time and length of the last period (cycles)
//   duty_valid         - one-cycle strobe when duty/period update
//   locked             - STABLE_N consecutive good periods seen
//   stuck_high/low     - no edge for 2*PERIOD_NOM cycles at level 1/0
// -----------------------------------------------------------------------------
module pump_duty_decoder
    import pump_duty_decoder_pkg::*;
#(
    parameter int PERIOD_NOM = PERIOD_NOM_DEF,
    parameter int PERIOD_TOL = PERIOD_TOL_DEF,
    parameter int STABLE_N   = STABLE_N_DEF
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              pump_in,
    output logic [CNT_W-1:0]  duty,
    output logic [CNT_W-1:0]  period,
    output logic              duty_valid,
    output logic              locked,
    output logic              stuck_high,
    output logic              stuck_low
);

    localparam int GOOD_W = $clog2(STABLE_N + 1);

    localparam logic [CNT_W-1:0]  NOM_C     = CNT_W'(PERIOD_NOM);
    localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(PERIOD_TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(2 * PERIOD_NOM);
    localparam logic [GOOD_W-1:0] STABLE_C  = GOOD_W'(STABLE_N);

    logic level_s;
    logic rise_s;

    pdd_state_e       state_r,      state_s;
    logic [CNT_W-1:0] period_cnt_r, period_cnt_s;
    logic [CNT_W-1:0] high_cnt_r,   high_cnt_s;
    logic [CNT_W-1:0] duty_r,       duty_s;
    logic [CNT_W-1:0] period_r,     period_s;
    logic             dv_r,         dv_s;
    logic             locked_r,     locked_s;
    logic             stuck_high_r, stuck_high_s;
    logic             stuck_low_r,  stuck_low_s;
    logic [GOOD_W-1:0] good_cnt_r,  good_cnt_s;
    logic             have_prev_r,  have_prev_s;

    logic              period_ok_s;
    logic              duty_ok_s;
    logic [GOOD_W-1:0] good_inc_s;

    pump_edge_sync u_edge (
        .clk_in  (clk_in),
        .reset   (reset),
        .pump_in (pump_in),
        .level   (level_s),
        .rise    (rise_s)
    );

    // The duty comparison needs a previous duty from the same run of edges;
    // after WAIT_RISE the first measurement has none and is never good.
    assign period_ok_s = (abs_diff(period_cnt_r, NOM_C) <= TOL_C);
    assign duty_ok_s   = have_prev_r && (abs_diff(high_cnt_r, duty_r) <= 17'd1);
    assign good_inc_s  = (good_cnt_r >= STABLE_C) ? STABLE_C : (good_cnt_r + 1'b1);

    // Next-state and output logic of the measurement FSM.
    always_comb begin
        state_s      = state_r;
        period_cnt_s = period_cnt_r;
        high_cnt_s   = high_cnt_r;
        duty_s       = duty_r;
        period_s     = period_r;
        dv_s         = 1'b0;
        locked_s     = locked_r;
        stuck_high_s = stuck_high_r;
        stuck_low_s  = stuck_low_r;
        good_cnt_s   = good_cnt_r;
        have_prev_s  = have_prev_r;

        case (state_r)
            ST_IDLE: begin
                period_cnt_s = 17'd0;
                high_cnt_s   = 17'd0;
                good_cnt_s   = '0;
                have_prev_s  = 1'b0;
                locked_s     = 1'b0;
                if (enable) begin
                    state_s = ST_WAIT_RISE;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WAIT_RISE: begin
                if (!enable) begin
                    state_s      = ST_IDLE;
                    period_cnt_s = 17'd0;
                    high_cnt_s   = 17'd0;
                    good_cnt_s   = '0;
                    have_prev_s  = 1'b0;
                    locked_s     = 1'b0;
                end else if (rise_s) begin
                    // First edge only opens a measurement window.
                    state_s      = ST_MEASURE;
                    period_cnt_s = 17'd1;
                    high_cnt_s   = 17'd1;
                    stuck_high_s = 1'b0;
                    stuck_low_s  = 1'b0;
                end else begin
                    state_s = ST_WAIT_RISE;
                end
            end

            ST_MEASURE: begin
                if (!enable) begin
                    // Partial period is dropped; published values hold.
                    state_s      = ST_IDLE;
                    period_cnt_s = 17'd0;
                    high_cnt_s   = 17'd0;
                    good_cnt_s   = '0;
                    have_prev_s  = 1'b0;
                    locked_s     = 1'b0;
                end else if (rise_s) begin
                    // A rise wins over a coincident timeout.
                    period_s     = period_cnt_r;
                    duty_s       = high_cnt_r;
                    dv_s         = 1'b1;
                    period_cnt_s = 17'd1;
                    high_cnt_s   = 17'd1;
                    have_prev_s  = 1'b1;
                    stuck_high_s = 1'b0;
                    stuck_low_s  = 1'b0;
                    if (period_ok_s && duty_ok_s) begin
                        good_cnt_s = good_inc_s;
                        locked_s   = (good_inc_s == STABLE_C);
                    end else begin
                        good_cnt_s = '0;
                        locked_s   = 1'b0;
                    end
                end else if (period_cnt_r >= TIMEOUT_C) begin
                    // No edge for two nominal periods: report a stuck line.
                    state_s      = ST_WAIT_RISE;
                    period_s     = TIMEOUT_C;
                    dv_s         = 1'b1;
                    locked_s     = 1'b0;
                    good_cnt_s   = '0;
                    have_prev_s  = 1'b0;
                    stuck_high_s = level_s;
                    stuck_low_s  = ~level_s;
                    if (level_s) begin
                        duty_s = NOM_C;
                    end else begin
                        duty_s = 17'd0;
                    end
                end else begin
                    period_cnt_s = period_cnt_r + 17'd1;
                    if (level_s) begin
                        high_cnt_s = high_cnt_r + 17'd1;
                    end else begin
                        high_cnt_s = high_cnt_r;
                    end
                end
            end

            default: begin
                state_s      = ST_IDLE;
                period_cnt_s = 17'd0;
                high_cnt_s   = 17'd0;
                good_cnt_s   = '0;
                have_prev_s  = 1'b0;
                locked_s     = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            period_cnt_r <= 17'd0;
            high_cnt_r   <= 17'd0;
            duty_r       <= 17'd0;
            period_r     <= 17'd0;
            dv_r         <= 1'b0;
            locked_r     <= 1'b0;
            stuck_high_r <= 1'b0;
            stuck_low_r  <= 1'b0;
            good_cnt_r   <= '0;
            have_prev_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            period_cnt_r <= period_cnt_s;
            high_cnt_r   <= high_cnt_s;
            duty_r       <= duty_s;
            period_r     <= period_s;
            dv_r         <= dv_s;
            locked_r     <= locked_s;
            stuck_high_r <= stuck_high_s;
            stuck_low_r  <= stuck_low_s;
            good_cnt_r   <= good_cnt_s;
            have_prev_r  <= have_prev_s;
        end
    end

    assign duty       = duty_r;
    assign period     = period_r;
    assign duty_valid = dv_r;
    assign locked     = locked_r;
    assign stuck_high = stuck_high_r;
    assign stuck_low  = stuck_low_r;

endmodule

// File: tb/tb_pump_duty_decoder.sv
// -----------------------------------------------------------------------------
// tb_pump_duty_decoder
// Directed bench for pump_duty_decoder. The decoder is built with a scaled
// nominal period (200 cycles, tolerance 4) so that the same scenarios as the
// full-size design run in a few thousand cycles: timeout is at 400 cycles.
// -----------------------------------------------------------------------------
module tb_pump_duty_decoder;

    localparam int NOM = 200;
    localparam int TOL = 4;
    localparam int STB = 4;

    logic        clk_in;
    logic        reset;
    logic        enable;
    logic        pump_in;
    logic [16:0] duty;
    logic [16:0] period;
    logic        duty_valid;
    logic        locked;
    logic        stuck_high;
    logic        stuck_low;

    int n_tests = 0;
    int n_fail  = 0;

    // Log of every strobe seen: duty, period and locked at the strobe.
    logic [16:0] sd [64];
    logic [16:0] sp [64];
    logic        sl [64];
    int          n_sb = 0;

    pump_duty_decoder #(
        .PERIOD_NOM (NOM),
        .PERIOD_TOL (TOL),
        .STABLE_N   (STB)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .pump_in    (pump_in),
        .duty       (duty),
        .period     (period),
        .duty_valid (duty_valid),
        .locked     (locked),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (duty_valid === 1'b1 && n_sb < 64) begin
            sd[n_sb] = duty;
            sp[n_sb] = period;
            sl[n_sb] = locked;
            n_sb     = n_sb + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One PWM period: hi cycles high then low for the rest of per cycles.
    task automatic pulse(input int hi, input int per);
        pump_in = 1'b1;
        repeat (hi) @(negedge clk_in);
        pump_in = 1'b0;
        repeat (per - hi) @(negedge clk_in);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        int base;
        reset   = 1'b1;
        enable  = 1'b0;
        pump_in = 1'b0;
        wait_cyc(3);
        chk("rst_duty",   duty,       32'd0);
        chk("rst_period", period,     32'd0);
        chk("rst_dv",     duty_valid, 32'd0);
        chk("rst_locked", locked,     32'd0);
        chk("rst_sh",     stuck_high, 32'd0);
        chk("rst_sl",     stuck_low,  32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        wait_cyc(5);

        // 11 rises at 50 % duty -> 10 strobes, locked from the 5th.
        for (int i = 0; i < 11; i++) pulse(100, 200);
        chk("nom_count", n_sb, 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk("nom_duty",   sd[i], 32'd100);
            chk("nom_period", sp[i], 32'd200);
            chk("nom_locked", sl[i], (i >= 4) ? 32'd1 : 32'd0);
        end

        // Latency from first sampled high to strobe is 3 cycles.
        pump_in = 1'b1;
        wait_cyc(3);
        chk("lat_dv_early", duty_valid, 32'd0);
        wait_cyc(1);
        chk("lat_dv",     duty_valid, 32'd1);
        chk("lat_duty",   duty,       32'd100);
        chk("lat_period", period,     32'd200);
        chk("lat_locked", locked,     32'd1);
        wait_cyc(96);
        pump_in = 1'b0;
        wait_cyc(100);

        // 1-cycle high pulses: first breaks lock, four good ones relock.
        for (int i = 0; i < 6; i++) pulse(1, 200);
        chk("min_count",  n_sb,   32'd17);
        chk("min_duty",   sd[12], 32'd1);
        chk("min_period", sp[12], 32'd200);
        chk("min_unlock", sl[12], 32'd0);
        chk("min_pre",    sl[15], 32'd0);
        chk("min_relock", sl[16], 32'd1);

        // Line held low past the timeout.
        wait_cyc(300);
        chk("sl_flag",   stuck_low,  32'd1);
        chk("sl_sh",     stuck_high, 32'd0);
        chk("sl_duty",   duty,       32'd0);
        chk("sl_period", period,     32'd400);
        chk("sl_locked", locked,     32'd0);
        chk("sl_count",  n_sb,       32'd18);
        pulse(100, 200);
        chk("sl_clear",   stuck_low, 32'd0);
        chk("sl_nostrb",  n_sb,      32'd18);

        // Line held high past the timeout.
        pump_in = 1'b1;
        wait_cyc(500);
        chk("sh_flag",   stuck_high, 32'd1);
        chk("sh_sl",     stuck_low,  32'd0);
        chk("sh_duty",   duty,       32'd200);
        chk("sh_period", period,     32'd400);
        chk("sh_count",  n_sb,       32'd20);
        chk("sh_prev",   sd[18],     32'd100);
        pump_in = 1'b0;
        wait_cyc(20);

        // Period just outside tolerance: strobes but never locks.
        for (int i = 0; i < 7; i++) pulse(100, 205);
        chk("tol_sh_clr", stuck_high, 32'd0);
        chk("tol_count",  n_sb,       32'd26);
        chk("tol_period", sp[25],     32'd205);
        chk("tol_duty",   sd[25],     32'd100);
        for (int i = 20; i < 26; i++) chk("tol_locked", sl[i], 32'd0);

        // Duty alternating by 2: never locks.
        for (int i = 0; i < 8; i++) pulse((i % 2 == 0) ? 100 : 102, 200);
        chk("alt_count", n_sb,   32'd34);
        chk("alt_d0",    sd[27], 32'd100);
        chk("alt_d1",    sd[28], 32'd102);
        chk("alt_per",   sp[28], 32'd200);
        for (int i = 26; i < 34; i++) chk("alt_locked", sl[i], 32'd0);

        // Relock, then drop enable mid-period.
        for (int i = 0; i < 6; i++) pulse(100, 200);
        chk("en_lock", sl[39], 32'd1);
        pump_in = 1'b1;
        wait_cyc(50);
        enable = 1'b0;
        wait_cyc(10);
        chk("en_locked", locked,     32'd0);
        chk("en_duty",   duty,       32'd100);
        chk("en_period", period,     32'd200);
        chk("en_dv",     duty_valid, 32'd0);
        chk("en_count",  n_sb,       32'd41);
        pump_in = 1'b0;
        enable  = 1'b1;
        wait_cyc(150);
        pulse(100, 200);
        chk("en_first", n_sb, 32'd41);
        pulse(100, 200);
        chk("en_second", n_sb,   32'd42);
        chk("en_d",      sd[41], 32'd100);
        chk("en_p",      sp[41], 32'd200);

        // Reset in the middle of a period.
        pump_in = 1'b1;
        wait_cyc(30);
        pump_in = 1'b0;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(1);
        chk("mr_duty",   duty,       32'd0);
        chk("mr_period", period,     32'd0);
        chk("mr_dv",     duty_valid, 32'd0);
        chk("mr_locked", locked,     32'd0);
        chk("mr_sh",     stuck_high, 32'd0);
        chk("mr_sl",     stuck_low,  32'd0);
        reset = 1'b0;
        wait_cyc(5);
        base = n_sb;
        pulse(100, 200);
        chk("mr_first",  n_sb - base, 32'd0);
        pulse(100, 200);
        chk("mr_second", n_sb - base, 32'd1);
        chk("mr_d",      sd[base],    32'd100);
        chk("mr_p",      sp[base],    32'd200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
